nios2_ht18_wang_fu_oci_dct_unpacker: RTL and testbench

//   Reads packed OCI data-capture-trace (DCT) words and serialises them.
//   The OCI side writes a 30-bit dct_buffer holding up to 15 2-bit slots,

---
 rtl/nios2_ht18_wang_fu_oci_dct_unpacker_if.sv | 32 +++
 rtl/nios2_ht18_wang_fu_oci_dct_unpacker.sv | 101 ++++++++++
 tb/tb_nios2_ht18_wang_fu_oci_dct_unpacker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_ht18_wang_fu_oci_dct_unpacker_if.sv
// Bundle of the OCI DCT capture inputs and the serialised trace-slot stream.
// Latency: none (wires only).
// Backpressure: slot_ready from the sink stalls the slot stream.
interface nios2_ht18_wang_fu_oci_dct_unpacker_if #(
    parameter int BUF_W  = 30,
    parameter int SLOT_W = 2,
    parameter int CNT_W  = 4
);
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              dct_load;
    logic [SLOT_W-1:0] slot_data;
    logic              slot_valid;
    logic              slot_ready;
    logic              slot_last;
    logic              dct_busy;
    logic              dct_overflow;
    logic              test_ending;
    logic              test_has_ended;

    // OCI / trace-sink side: drives capture words and accepts slots.
    modport master (
        output dct_buffer, dct_count, dct_load, slot_ready, test_ending,
        input  slot_data, slot_valid, slot_last, dct_busy, dct_overflow, test_has_ended
    );

    // Unpacker side.
    modport slave (
        input  dct_buffer, dct_count, dct_load, slot_ready, test_ending,
        output slot_data, slot_valid, slot_last, dct_busy, dct_overflow, test_has_ended
    );
endinterface

// File: rtl/nios2_ht18_wang_fu_oci_dct_unpacker.sv
// Serialises captured OCI DCT words into 2-bit trace slots, slot 0 first.
// Latency: first slot valid 1 cycle after dct_load; one slot per cycle with ready held.
// Backpressure: slot_ready low holds data/last stable; loads arriving while busy are dropped (sticky overflow).
module nios2_ht18_wang_fu_oci_dct_unpacker #(
    parameter int BUF_W  = 30,
    parameter int SLOT_W = 2,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic reset,
    nios2_ht18_wang_fu_oci_dct_unpacker_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BUF_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             end_pending_q, end_pending_d;
    logic             overflow_q, overflow_d;

    logic             xfer;
    logic             final_xfer;
    logic             load_ok;

    // Next-state logic: capture, shift-out, drop detection and end-of-test sequencing.
    always_comb begin
        xfer          = (state_q == ST_SHIFT) && bus.slot_ready;
        final_xfer    = xfer && (rem_q == CNT_W'(1));
        load_ok       = bus.dct_load && (bus.dct_count != '0);

        state_d       = state_q;
        shreg_d       = shreg_q;
        rem_d         = rem_q;
        overflow_d    = overflow_q;
        end_pending_d = end_pending_q | bus.test_ending;

        case (state_q)
            ST_IDLE: begin
                // A real word wins over ending so captured data is never lost.
                if (load_ok) begin
                    shreg_d = bus.dct_buffer;
                    rem_d   = bus.dct_count;
                    state_d = ST_SHIFT;
                end else if (end_pending_d) begin
                    state_d = ST_ENDED;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    shreg_d = shreg_q >> SLOT_W;
                    rem_d   = rem_q - CNT_W'(1);
                end
                if (final_xfer) begin
                    // Reload on the last transfer keeps the stream bubble-free.
                    if (load_ok) begin
                        shreg_d = bus.dct_buffer;
                        rem_d   = bus.dct_count;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.dct_load) begin
                    overflow_d = 1'b1;
                end
            end
            ST_ENDED: begin
                state_d = ST_ENDED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            rem_q         <= '0;
            end_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            rem_q         <= rem_d;
            end_pending_q <= end_pending_d;
            overflow_q    <= overflow_d;
        end
    end

    // Outputs are pure functions of state so they hold steady under backpressure.
    assign bus.slot_valid     = (state_q == ST_SHIFT);
    assign bus.slot_data      = (state_q == ST_SHIFT) ? shreg_q[SLOT_W-1:0] : '0;
    assign bus.slot_last      = (state_q == ST_SHIFT) && (rem_q == CNT_W'(1));
    assign bus.dct_busy       = (state_q == ST_SHIFT);
    assign bus.dct_overflow   = overflow_q;
    assign bus.test_has_ended = (state_q == ST_ENDED);
endmodule

// File: tb/tb_nios2_ht18_wang_fu_oci_dct_unpacker.sv
// Directed self-checking bench for the DCT unpacker.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_nios2_ht18_wang_fu_oci_dct_unpacker;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    nios2_ht18_wang_fu_oci_dct_unpacker_if #(.BUF_W(30), .SLOT_W(2), .CNT_W(4)) bus ();

    nios2_ht18_wang_fu_oci_dct_unpacker #(.BUF_W(30), .SLOT_W(2), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.dct_buffer = '0; bus.dct_count = '0; bus.dct_load = 1'b0;
        bus.slot_ready = 1'b0; bus.test_ending = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.slot_valid, bus.slot_data, bus.slot_last, bus.dct_busy, bus.dct_overflow, bus.test_has_ended} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                {bus.slot_valid, bus.slot_data, bus.slot_last, bus.dct_busy, bus.dct_overflow, bus.test_has_ended});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: valid=%b busy=%b expected 0 0", bus.slot_valid, bus.dct_busy);
        end
    endtask

    // 30'hE4 holds slots 0,1,2,3 in order.
    task automatic test_basic();
        bus.dct_buffer = 30'h0000_00E4; bus.dct_count = 4'd4; bus.dct_load = 1'b1; bus.slot_ready = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.slot_valid !== 1'b1 || bus.slot_data !== 2'(i) || bus.slot_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_slot%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                    i, bus.slot_valid, bus.slot_data, bus.slot_last, i, (i == 3));
            end
            tick();
        end
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after: valid=%b busy=%b expected 0 0", bus.slot_valid, bus.dct_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        int         exp_idx;
        pat = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
        exp_idx = 0;
        bus.dct_buffer = 30'h0000_00E4; bus.dct_count = 4'd4; bus.dct_load = 1'b1; bus.slot_ready = 1'b0;
        tick();
        bus.dct_load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.slot_ready = pat[k];
            checks++;
            if (bus.slot_valid !== 1'b1 || bus.slot_data !== 2'(exp_idx) || bus.slot_last !== (exp_idx == 3)) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                    k, bus.slot_valid, bus.slot_data, bus.slot_last, exp_idx, (exp_idx == 3));
            end
            tick();
            if (pat[k]) exp_idx++;
        end
        bus.slot_ready = 1'b1;
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: valid=%b busy=%b expected 0 0", bus.slot_valid, bus.dct_busy);
        end
    endtask

    task automatic test_count_edges();
        bus.dct_buffer = 30'h3FFF_FFFF; bus.dct_count = 4'd0; bus.dct_load = 1'b1; bus.slot_ready = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0) begin
            errors++;
            $display("FAIL count0_noop: valid=%b busy=%b expected 0 0", bus.slot_valid, bus.dct_busy);
        end
        bus.dct_count = 4'd15; bus.dct_load = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (bus.slot_valid !== 1'b1 || bus.slot_data !== 2'b11 || bus.slot_last !== (i == 14)) begin
                errors++;
                $display("FAIL count15_slot%0d: valid=%b data=%0d last=%b expected 1 3 %b",
                    i, bus.slot_valid, bus.slot_data, bus.slot_last, (i == 14));
            end
            tick();
        end
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0) begin
            errors++;
            $display("FAIL count15_idle: valid=%b busy=%b expected 0 0", bus.slot_valid, bus.dct_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_b [3];
        exp_b = '{2'd3, 2'd1, 2'd2};
        // Word A: 30'h6 count 2 -> slots 2,1.
        bus.dct_buffer = 30'h0000_0006; bus.dct_count = 4'd2; bus.dct_load = 1'b1; bus.slot_ready = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        checks++;
        if (bus.slot_data !== 2'd2 || bus.slot_last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_a0: data=%0d last=%b expected 2 0", bus.slot_data, bus.slot_last);
        end
        tick();
        checks++;
        if (bus.slot_data !== 2'd1 || bus.slot_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a1: data=%0d last=%b expected 1 1", bus.slot_data, bus.slot_last);
        end
        // Word B on the final-transfer cycle: 30'h27 count 3 -> slots 3,1,2.
        bus.dct_buffer = 30'h0000_0027; bus.dct_count = 4'd3; bus.dct_load = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        checks++;
        if (bus.slot_valid !== 1'b1 || bus.slot_data !== 2'd3 || bus.dct_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: valid=%b data=%0d ovf=%b expected 1 3 0",
                bus.slot_valid, bus.slot_data, bus.dct_overflow);
        end
        // Load while rem=3 and stalled: dropped.
        bus.slot_ready = 1'b0;
        bus.dct_buffer = 30'h0000_0003; bus.dct_count = 4'd5; bus.dct_load = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        checks++;
        if (bus.dct_overflow !== 1'b1 || bus.slot_data !== 2'd3 || bus.slot_last !== 1'b0) begin
            errors++;
            $display("FAIL drop_overflow: ovf=%b data=%0d last=%b expected 1 3 0",
                bus.dct_overflow, bus.slot_data, bus.slot_last);
        end
        bus.slot_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.slot_valid !== 1'b1 || bus.slot_data !== exp_b[i] || bus.slot_last !== (i == 2)) begin
                errors++;
                $display("FAIL b2b_b%0d: valid=%b data=%0d last=%b expected 1 %0d %b",
                    i, bus.slot_valid, bus.slot_data, bus.slot_last, exp_b[i], (i == 2));
            end
            tick();
        end
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky: valid=%b ovf=%b expected 0 1", bus.slot_valid, bus.dct_overflow);
        end
    endtask

    task automatic test_reset_mid_word();
        bus.dct_buffer = 30'h0000_FFFF; bus.dct_count = 4'd8; bus.dct_load = 1'b1; bus.slot_ready = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        tick(); tick(); tick();  // rem now 5
        checks++;
        if (bus.slot_valid !== 1'b1 || bus.slot_data !== 2'd3) begin
            errors++;
            $display("FAIL midreset_pre: valid=%b data=%0d expected 1 3", bus.slot_valid, bus.slot_data);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.slot_valid, bus.slot_data, bus.slot_last, bus.dct_busy, bus.dct_overflow, bus.test_has_ended} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000000",
                {bus.slot_valid, bus.slot_data, bus.slot_last, bus.dct_busy, bus.dct_overflow, bus.test_has_ended});
        end
        tick();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0 || bus.slot_data !== 2'd0) begin
            errors++;
            $display("FAIL midreset_idle: valid=%b busy=%b data=%0d expected 0 0 0",
                bus.slot_valid, bus.dct_busy, bus.slot_data);
        end
    endtask

    task automatic test_end_of_test();
        bus.dct_buffer = 30'h0000_00E4; bus.dct_count = 4'd4; bus.dct_load = 1'b1; bus.slot_ready = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        tick(); tick();  // rem now 2, slot 2 showing
        bus.test_ending = 1'b1;
        checks++;
        if (bus.test_has_ended !== 1'b0 || bus.slot_data !== 2'd2) begin
            errors++;
            $display("FAIL end_rem2: ended=%b data=%0d expected 0 2", bus.test_has_ended, bus.slot_data);
        end
        tick();
        bus.test_ending = 1'b0;
        checks++;
        if (bus.test_has_ended !== 1'b0 || bus.slot_data !== 2'd3 || bus.slot_last !== 1'b1) begin
            errors++;
            $display("FAIL end_rem1: ended=%b data=%0d last=%b expected 0 3 1",
                bus.test_has_ended, bus.slot_data, bus.slot_last);
        end
        tick();
        checks++;
        if (bus.test_has_ended !== 1'b0 || bus.slot_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_drained: ended=%b valid=%b expected 0 0", bus.test_has_ended, bus.slot_valid);
        end
        tick();
        checks++;
        if (bus.test_has_ended !== 1'b1 || bus.slot_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_reached: ended=%b valid=%b expected 1 0", bus.test_has_ended, bus.slot_valid);
        end
        bus.dct_load = 1'b1;
        tick();
        bus.dct_load = 1'b0;
        tick();
        checks++;
        if (bus.slot_valid !== 1'b0 || bus.dct_busy !== 1'b0 || bus.dct_overflow !== 1'b0 || bus.test_has_ended !== 1'b1) begin
            errors++;
            $display("FAIL end_load_ignored: valid=%b busy=%b ovf=%b ended=%b expected 0 0 0 1",
                bus.slot_valid, bus.dct_busy, bus.dct_overflow, bus.test_has_ended);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.test_has_ended !== 1'b0) begin
            errors++;
            $display("FAIL end_cleared_by_reset: ended=%b expected 0", bus.test_has_ended);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_count_edges();
        test_back_to_back();
        test_reset_mid_word();
        test_end_of_test();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
